// File: rtl/drfm_pkg.sv
// Shared definitions for the DRFM Doppler profile scheduler.
//   - sched_state_e : scheduler FSM states
//   - DEF_SHIFT_W   : default width of the Doppler phase-increment word
//   - DEF_CNT_W     : default width of step/dwell counts and counters
//   - DEF_PARK_SHIFT: default Doppler word while no profile is playing
package drfm_pkg;

    localparam int          DEF_SHIFT_W    = 32;
    localparam int          DEF_CNT_W      = 16;
    localparam logic [31:0] DEF_PARK_SHIFT = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts sample strobes from 0 up to a terminal value and
// flags the strobe that completes the dwell.
// Ports:
//   M100CLK - system clock (rising edge)
//   reset   - asynchronous active-low reset
//   clr     - synchronous clear, wins over strobe
//   strobe  - count enable, one pulse per I/Q pair
//   term    - terminal count (dwell length minus one)
//   wrap    - high on the strobe that reaches term; the counter restarts at 0
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             M100CLK,
    input  logic             reset,
    input  logic             clr,
    input  logic             strobe,
    input  logic [CNT_W-1:0] term,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;

    // Combinational so the scheduler can act on the same strobe edge.
    assign wrap = strobe && (cnt_q == term);

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/doppler_profile_scheduler.sv
// Doppler profile scheduler: steps the doppler_shift word fed to the NCO and
// frequency shifter through a linear ramp (start, start+step, ...), holding
// each value for a programmed number of sample strobes, optionally looping.
// Ports:
//   M100CLK       - system clock (rising edge)
//   reset         - asynchronous active-low reset
//   cfg_valid     - host profile offer; accepted when cfg_ready is high
//   cfg_ready     - high only in IDLE (decoded from state)
//   cfg_start     - first Doppler word of the profile
//   cfg_step      - signed increment per step
//   cfg_count     - number of steps (0 treated as 1)
//   cfg_dwell     - sample strobes per step (0 treated as 1)
//   cfg_loop      - restart at cfg_start after the last step
//   trig          - starts playback from ARMED
//   abort         - returns to IDLE and parks the output; highest priority
//   sample_strobe - one pulse per I/Q pair from the deinterleaving arbiter
//   doppler_shift - registered Doppler word
//   shift_update  - one-cycle pulse coincident with a new doppler_shift
//   busy          - high in ARMED or RUN
//   done          - one-cycle pulse when a one-shot profile ends
module doppler_profile_scheduler
    import drfm_pkg::*;
#(
    parameter int                 SHIFT_W    = DEF_SHIFT_W,
    parameter int                 CNT_W      = DEF_CNT_W,
    parameter logic [SHIFT_W-1:0] PARK_SHIFT = SHIFT_W'(DEF_PARK_SHIFT)
) (
    input  logic               M100CLK,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [SHIFT_W-1:0] cfg_start,
    input  logic [SHIFT_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [CNT_W-1:0]   cfg_dwell,
    input  logic               cfg_loop,
    input  logic               trig,
    input  logic               abort,
    input  logic               sample_strobe,
    output logic [SHIFT_W-1:0] doppler_shift,
    output logic               shift_update,
    output logic               busy,
    output logic               done
);

    function automatic logic [CNT_W-1:0] clamp_min1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    sched_state_e              state_q, state_d;
    logic [SHIFT_W-1:0]        start_q, start_d;
    logic signed [SHIFT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          dwell_q, dwell_d;
    logic                      loop_q, loop_d;
    logic [CNT_W-1:0]          step_idx_q, step_idx_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      upd_q, upd_d;
    logic                      done_q, done_d;

    logic                      tmr_clr, tmr_en, tmr_wrap;

    // The dwell counter restarts on trig and on abort, and only advances
    // on strobes seen while playing.
    assign tmr_clr = abort || ((state_q == ARMED) && trig);
    assign tmr_en  = !abort && (state_q == RUN) && sample_strobe;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .M100CLK (M100CLK),
        .reset   (reset),
        .clr     (tmr_clr),
        .strobe  (tmr_en),
        .term    (dwell_q - CNT_W'(1)),
        .wrap    (tmr_wrap)
    );

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        step_d     = step_q;
        count_d    = count_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;
        step_idx_d = step_idx_q;
        shift_d    = shift_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;

        if (abort) begin
            state_d = IDLE;
            shift_d = PARK_SHIFT;
            upd_d   = (shift_q != PARK_SHIFT);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        start_d = cfg_start;
                        step_d  = $signed(cfg_step);
                        count_d = clamp_min1(cfg_count);
                        dwell_d = clamp_min1(cfg_dwell);
                        loop_d  = cfg_loop;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        shift_d    = start_q;
                        upd_d      = 1'b1;
                        step_idx_d = '0;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (tmr_wrap) begin
                        if (step_idx_q < count_q - CNT_W'(1)) begin
                            // Two's-complement add wraps modulo 2^SHIFT_W.
                            shift_d    = shift_q + $unsigned(step_q);
                            step_idx_d = step_idx_q + CNT_W'(1);
                            upd_d      = 1'b1;
                        end else if (loop_q) begin
                            shift_d    = start_q;
                            step_idx_d = '0;
                            upd_d      = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            start_q    <= '0;
            step_q     <= '0;
            count_q    <= '0;
            dwell_q    <= '0;
            loop_q     <= 1'b0;
            step_idx_q <= '0;
            shift_q    <= PARK_SHIFT;
            upd_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q    <= start_d;
            step_q     <= step_d;
            count_q    <= count_d;
            dwell_q    <= dwell_d;
            loop_q     <= loop_d;
            step_idx_q <= step_idx_d;
            shift_q    <= shift_d;
            upd_q      <= upd_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ready     = (state_q == IDLE);
    assign busy          = (state_q == ARMED) || (state_q == RUN);
    assign doppler_shift = shift_q;
    assign shift_update  = upd_q;
    assign done          = done_q;

endmodule

// File: tb/tb_doppler_profile_scheduler.sv
// Testbench for doppler_profile_scheduler: directed profile scenarios followed
// by a randomized input stream, all checked against a strobe-counting model
// that derives the expected Doppler word as start + (n/dwell mod count)*step.
module tb_doppler_profile_scheduler;

    localparam logic [31:0] PARK = 32'h0;

    logic        M100CLK = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_start;
    logic [31:0] cfg_step;
    logic [15:0] cfg_count;
    logic [15:0] cfg_dwell;
    logic        cfg_loop;
    logic        trig;
    logic        abort;
    logic        sample_strobe;
    logic [31:0] doppler_shift;
    logic        shift_update;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: 0 idle, 1 armed, 2 playing, 3 finished
    int          m_state;
    logic [31:0] m_start, m_step;
    int          m_count, m_dwell;
    logic        m_loop;
    longint      m_n;
    logic [31:0] exp_shift;
    logic        exp_upd, exp_done;

    doppler_profile_scheduler dut (
        .M100CLK       (M100CLK),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_start     (cfg_start),
        .cfg_step      (cfg_step),
        .cfg_count     (cfg_count),
        .cfg_dwell     (cfg_dwell),
        .cfg_loop      (cfg_loop),
        .trig          (trig),
        .abort         (abort),
        .sample_strobe (sample_strobe),
        .doppler_shift (doppler_shift),
        .shift_update  (shift_update),
        .busy          (busy),
        .done          (done)
    );

    always #5 M100CLK = ~M100CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_start   = '0;
        m_step    = '0;
        m_count   = 0;
        m_dwell   = 0;
        m_loop    = 1'b0;
        m_n       = 0;
        exp_shift = PARK;
        exp_upd   = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        longint k;
        exp_upd  = 1'b0;
        exp_done = 1'b0;
        if (abort) begin
            exp_upd   = (exp_shift != PARK);
            exp_shift = PARK;
            m_state   = 0;
        end else begin
            case (m_state)
                0: if (cfg_valid) begin
                    m_start = cfg_start;
                    m_step  = cfg_step;
                    m_count = (cfg_count == 0) ? 1 : int'(cfg_count);
                    m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                    m_loop  = cfg_loop;
                    m_state = 1;
                end
                1: if (trig) begin
                    m_n       = 0;
                    exp_shift = m_start;
                    exp_upd   = 1'b1;
                    m_state   = 2;
                end
                2: if (sample_strobe) begin
                    m_n++;
                    if (m_n % m_dwell == 0) begin
                        k = m_n / m_dwell;
                        if (k < m_count || m_loop) begin
                            exp_shift = m_start + 32'(k % m_count) * m_step;
                            exp_upd   = 1'b1;
                        end else begin
                            exp_done = 1'b1;
                            m_state  = 3;
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_shift"}, doppler_shift, exp_shift);
        chk({tag, "_upd"},   32'(shift_update), 32'(exp_upd));
        chk({tag, "_done"},  32'(done), 32'(exp_done));
        chk({tag, "_busy"},  32'(busy), 32'(m_state == 1 || m_state == 2));
        chk({tag, "_ready"}, 32'(cfg_ready), 32'(m_state == 0));
    endtask

    task automatic tick(input string tag);
        @(posedge M100CLK);
        model_step();
        #1;
        chk_all(tag);
    endtask

    task automatic load(input logic [31:0] s, input logic [31:0] st,
                        input logic [15:0] c, input logic [15:0] d, input logic l);
        cfg_start = s; cfg_step = st; cfg_count = c; cfg_dwell = d; cfg_loop = l;
        cfg_valid = 1'b1;
        tick("load");
        cfg_valid = 1'b0;
    endtask

    task automatic do_trig();
        trig = 1'b1;
        tick("trig");
        trig = 1'b0;
    endtask

    // n strobes, each preceded by gap quiet cycles; ends right after a strobe edge.
    task automatic strobes(input int n, input int gap, input string tag);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) tick(tag);
            sample_strobe = 1'b1;
            tick(tag);
            sample_strobe = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0;
        cfg_valid = 0; cfg_start = 0; cfg_step = 0; cfg_count = 0; cfg_dwell = 0;
        cfg_loop = 0; trig = 0; abort = 0; sample_strobe = 0;
        model_reset();
        #1;
        chk_all("reset");
        #11 reset = 1'b1;

        // 1: one-shot ramp 0x1000, 0x1100, 0x1200
        load(32'h1000, 32'h100, 16'd3, 16'd2, 1'b0);
        do_trig();
        chk("t1_first", doppler_shift, 32'h1000);
        strobes(2, 1, "t1");
        chk("t1_second", doppler_shift, 32'h1100);
        strobes(4, 1, "t1");
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_final", doppler_shift, 32'h1200);
        tick("t1_after");
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: looping ramp over three periods
        load(32'h1000, 32'h100, 16'd3, 16'd2, 1'b1);
        do_trig();
        strobes(6, 1, "t2");
        chk("t2_wrap_val", doppler_shift, 32'h1000);
        chk("t2_wrap_upd", 32'(shift_update), 32'd1);
        strobes(12, 1, "t2");
        abort = 1'b1; tick("t2_abort"); abort = 1'b0;

        // 3: negative step across zero
        load(32'h80, 32'hFFFF_FF80, 16'd3, 16'd1, 1'b0);
        do_trig();
        chk("t3_v0", doppler_shift, 32'h80);
        strobes(1, 0, "t3");
        chk("t3_v1", doppler_shift, 32'h0);
        strobes(1, 2, "t3");
        chk("t3_v2", doppler_shift, 32'hFFFF_FF80);
        strobes(1, 0, "t3");
        chk("t3_done", 32'(done), 32'd1);
        tick("t3_after");

        // 4: zero count/dwell behave as one
        load(32'h55, 32'h7, 16'd0, 16'd0, 1'b0);
        sample_strobe = 1'b1;
        do_trig();
        sample_strobe = 1'b0;
        chk("t4_v0", doppler_shift, 32'h55);
        strobes(1, 1, "t4");
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_hold", doppler_shift, 32'h55);
        tick("t4_after");

        // 5: abort with a boundary strobe and trig in the same cycle
        load(32'h10, 32'h1, 16'd4, 16'd2, 1'b0);
        do_trig();
        strobes(1, 0, "t5");
        abort = 1'b1; trig = 1'b1; sample_strobe = 1'b1;
        tick("t5_abort");
        abort = 1'b0; trig = 1'b0; sample_strobe = 1'b0;
        chk("t5_park", doppler_shift, PARK);
        chk("t5_ready", 32'(cfg_ready), 32'd1);
        chk("t5_nodone", 32'(done), 32'd0);
        tick("t5_after");

        // 6a: cfg_valid held through ARMED and RUN must not reload
        cfg_start = 32'h200; cfg_step = 32'h10; cfg_count = 16'd2; cfg_dwell = 16'd1; cfg_loop = 0;
        cfg_valid = 1'b1;
        tick("t6_load");
        cfg_start = 32'hDEAD; cfg_step = 32'h1; cfg_count = 16'd9; cfg_dwell = 16'd5;
        do_trig();
        chk("t6_start", doppler_shift, 32'h200);
        strobes(1, 0, "t6");
        chk("t6_step", doppler_shift, 32'h210);
        chk("t6_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        strobes(1, 0, "t6");
        tick("t6_after");

        // 6b: trig while idle does nothing
        trig = 1'b1; tick("t6_idle_trig"); trig = 1'b0;
        chk("t6_idle_busy", 32'(busy), 32'd0);

        // 6c: asynchronous reset in the middle of a profile
        load(32'h300, 32'h20, 16'd5, 16'd3, 1'b1);
        do_trig();
        strobes(3, 0, "t6c");
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_all("t6c_async");
        chk("t6c_park", doppler_shift, PARK);
        #4 reset = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_valid     = ($urandom_range(0, 7) == 0);
            cfg_start     = $urandom;
            cfg_step      = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            cfg_count     = 16'($urandom_range(0, 4));
            cfg_dwell     = 16'($urandom_range(0, 3));
            cfg_loop      = 1'($urandom_range(0, 1));
            trig          = ($urandom_range(0, 5) == 0);
            sample_strobe = 1'($urandom_range(0, 1));
            abort         = ($urandom_range(0, 63) == 0);
            tick("rand");
        end
        cfg_valid = 0; trig = 0; sample_strobe = 0; abort = 0;
        tick("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/doppler_profile_scheduler.md
Name: doppler_profile_scheduler

Overview:
Sequences the doppler_shift word fed to the NCO/frequency-shift datapath, so the DRFM can replay a stepped Doppler profile (a linear ramp, optionally looped) instead of a static shift. The profile advances on sample-pair strobes from the deinterleaving arbiter (its one-cycle ready pulse). A host loads a profile over a valid/ready handshake, and an external trigger starts playback.

Parameters:
SHIFT_W, 32, width of doppler_shift, cfg_start and cfg_step
CNT_W, 16, width of cfg_count, cfg_dwell and the internal counters
PARK_SHIFT, 32'h0, doppler_shift value after reset and after abort

Ports:
M100CLK  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  host profile offer
cfg_ready  out  1  high only in IDLE
cfg_start  in  SHIFT_W  first phase increment
cfg_step  in  SHIFT_W  signed two's-complement increment per step
cfg_count  in  CNT_W  number of profile steps (0 is treated as 1)
cfg_dwell  in  CNT_W  sample strobes per step (0 is treated as 1)
cfg_loop  in  1  1 = restart the profile at cfg_start after the last step
trig  in  1  starts playback; honoured only in ARMED
abort  in  1  synchronous abort; highest priority
sample_strobe  in  1  one-cycle pulse per I/Q pair
doppler_shift  out  SHIFT_W  registered output to the NCO and frequency shifter
shift_update  out  1  one-cycle pulse in the cycle doppler_shift changes value
busy  out  1  high in ARMED or RUN
done  out  1  one-cycle pulse when a one-shot profile ends

Behaviour:
- Reset (reset low, asynchronous) forces: state IDLE; doppler_shift = PARK_SHIFT; shift_update, done and busy = 0; cfg_ready = 1; all counters and config registers = 0.
- States are IDLE, ARMED, RUN and DONE.
- IDLE:
  - cfg_ready = 1.
  - cfg_valid high latches all cfg_* inputs, with count and dwell clamped to a minimum of 1. Next state is ARMED.
  - trig is ignored.
- ARMED:
  - cfg_ready = 0.
  - trig high gives, on the next edge: doppler_shift = cfg_start, shift_update = 1, step_idx = 0, dwell_cnt = 0. Next state is RUN.
  - A sample_strobe in the trig cycle is not counted.
- RUN:
  - Each sample_strobe increments dwell_cnt.
  - When a strobe arrives with dwell_cnt == dwell-1, dwell_cnt clears and exactly one of the following applies:
    - step_idx < count-1: doppler_shift += step (wraps modulo 2^SHIFT_W), step_idx++, shift_update pulses.
    - Last step and loop = 1: doppler_shift = start, step_idx = 0, shift_update pulses.
    - Last step and loop = 0: go to DONE. doppler_shift holds its final value and there is no shift_update.
  - trig and cfg_valid are ignored in RUN.
- DONE:
  - Lasts one cycle, with done = 1, then returns to IDLE.
  - doppler_shift keeps the last profile value until the next trig or abort.
- abort in any state gives, on the next edge: IDLE, doppler_shift = PARK_SHIFT, and shift_update = 1 only if the value changed.
  - abort beats trig, sample_strobe and cfg_valid in the same cycle.
  - A handshake in the same cycle as abort is not accepted.
- Latency:
  - trig to new doppler_shift: 1 cycle.
  - Final strobe of a dwell to new doppler_shift: 1 cycle.
  - shift_update is coincident with the new value.
- If shift_update pulses and the step is 0, doppler_shift is unchanged; the pulse still fires at a step boundary.
- Strobes arriving in IDLE, ARMED or DONE are ignored.
- No combinational path from any input to any output, except cfg_ready, which depends on state only.

Decomposition:
- Shared package (drfm_pkg):
  - state enum {IDLE, ARMED, RUN, DONE};
  - SHIFT_W and CNT_W defaults;
  - PARK_SHIFT default.
- One natural sub-module, dwell_timer: counts sample_strobe up to a loaded terminal value and emits a wrap pulse, with a synchronous clear and the asynchronous reset. The scheduler FSM and step accumulator stay in the top block.

Test Plan:
1. Reset release, then load start=0x1000, step=0x100, count=3, dwell=2, loop=0, and trig; strobe every 2 cycles.
   Required: doppler_shift sequence 0x1000, 0x1100, 0x1200, each value held for 2 strobes; then done pulses once, the final value stays 0x1200, and busy falls.
2. Loop mode, same profile with loop=1.
   Required: after 0x1200 and 2 strobes, doppler_shift returns to 0x1000 with shift_update; no done pulse across 3 full periods.
3. Wrap and negative step: start=0x0000_0080, step=0xFFFF_FF80 (-128), count=3, dwell=1.
   Required: values 0x80, 0x0, 0xFFFF_FF80.
4. Clamping: count=0, dwell=0, start=0x55.
   Required: 0x55 is output for exactly 1 strobe, then done.
5. abort asserted mid-RUN together with a step-boundary strobe and trig.
   Required: next cycle IDLE, doppler_shift = PARK_SHIFT, cfg_ready = 1, no done pulse.
6. Handshake and ignore rules:
   - cfg_valid held through ARMED and RUN: no reload, cfg_ready = 0.
   - trig in IDLE: no effect.
   - Asynchronous reset pulsed mid-RUN: outputs return to reset values immediately, without waiting for a clock edge.
